// File: rtl/elevator_button_conditioner_if.sv
// rtl/elevator_button_conditioner_if.sv - button conditioner signal bundle
interface elevator_button_conditioner_if;
  logic [3:0] fb_raw;
  logic [3:0] call_raw;
  logic       en;
  logic [3:0] fb_level;
  logic [3:0] call_level;
  logic [3:0] fb_press;
  logic [3:0] call_press;
  logic [7:0] stuck;

  modport master (
    output fb_raw, call_raw, en,
    input  fb_level, call_level, fb_press, call_press, stuck
  );

  modport slave (
    input  fb_raw, call_raw, en,
    output fb_level, call_level, fb_press, call_press, stuck
  );
endinterface

// File: rtl/elevator_button_conditioner.sv
// rtl/elevator_button_conditioner.sv - sync, debounce, edge detect and stuck flag for 8 buttons
module elevator_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int STUCK_CYCLES    = 1000000,
  parameter int STUCK_W         = 20
) (
  input logic                         clk,
  input logic                         rst_n,
  elevator_button_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  // Channels 0-3 are floor buttons, 4-7 are hall calls.
  logic [7:0]         w_raw;
  logic [7:0]         r_s1;
  logic [7:0]         r_s2;
  logic [7:0]         r_stable;
  logic [CNT_W-1:0]   r_cnt [8];
  logic [STUCK_W-1:0] r_stuck_cnt [8];
  logic [7:0]         r_press;
  logic [7:0]         r_stuck;
  logic [7:0]         w_qual;
  logic [7:0]         w_rise;
  logic [7:0]         w_fall;

  assign w_raw = {bus.call_raw, bus.fb_raw};

  // A channel qualifies on the edge where the mismatch has lasted the full debounce window.
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < 8; i++) begin
      w_qual[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
    w_rise = w_qual & r_s2;
    w_fall = w_qual & ~r_s2;
  end

  // Two-flop synchroniser for the asynchronous button lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: any agreement with the stable level restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_qual[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stuck counter saturates while held; cleared on the same edge the level falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stuck <= '0;
      for (int i = 0; i < 8; i++) r_stuck_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_fall[i]) begin
          r_stuck_cnt[i] <= '0;
          r_stuck[i]     <= 1'b0;
        end else begin
          if (r_stable[i] && (r_stuck_cnt[i] != STUCK_MAX)) begin
            r_stuck_cnt[i] <= r_stuck_cnt[i] + STUCK_W'(1);
          end
          r_stuck[i] <= (r_stuck_cnt[i] == STUCK_MAX);
        end
      end
    end
  end

  // Press pulse coincides with the rising stable edge; a press during en=0 is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press <= '0;
    end else begin
      r_press <= w_rise & {8{bus.en}};
    end
  end

  assign bus.fb_level   = r_stable[3:0];
  assign bus.call_level = r_stable[7:4];
  assign bus.fb_press   = r_press[3:0];
  assign bus.call_press = r_press[7:4];
  assign bus.stuck      = r_stuck;

endmodule

// File: tb/tb_elevator_button_conditioner.sv
// tb/tb_elevator_button_conditioner.sv - self-checking bench for elevator_button_conditioner
module tb_elevator_button_conditioner;
  localparam int DB = 4;
  localparam int ST = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  elevator_button_conditioner_if bus ();

  elevator_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3),
    .STUCK_CYCLES(ST),
    .STUCK_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  fb;
    logic [3:0]  call;
    logic        en;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // {stuck, call_press, fb_press, call_level, fb_level}
  function automatic logic [23:0] outs();
    return {bus.stuck, bus.call_press, bus.fb_press, bus.call_level, bus.fb_level};
  endfunction

  function automatic void add(int n, logic [3:0] fb, logic [3:0] call, logic e,
                              logic [3:0] fl, logic [3:0] cl, logic [3:0] fp,
                              logic [3:0] cp, logic [7:0] st);
    vec_t v;
    v.fb   = fb;
    v.call = call;
    v.en   = e;
    v.exp  = {st, cp, fp, cl, fl};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [23:0] got, logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] fb, logic [3:0] call, logic e);
    @(negedge clk);
    bus.fb_raw   = fb;
    bus.call_raw = call;
    bus.en       = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  edges;
    bit  seen;

    rst_n        = 1'b0;
    bus.fb_raw   = '0;
    bus.call_raw = '0;
    bus.en       = 1'b1;
    #12;
    check("reset_state", outs(), 24'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle
    add(2, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // clean press fb[2], then release
    add(5, 4'h4, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'h4, 4'h0, 1, 4'h4, 4'h0, 4'h4, 4'h0, 8'h00);
    add(1, 4'h4, 4'h0, 1, 4'h4, 4'h0, 4'h0, 4'h0, 8'h00);
    add(5, 4'h0, 4'h0, 1, 4'h4, 4'h0, 4'h0, 4'h0, 8'h00);
    add(2, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // press fb[0] with en low at the qualifying edge: no pulse, none replayed
    add(5, 4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'h1, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    add(2, 4'h1, 4'h0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    add(5, 4'h0, 4'h0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 8'h00);
    add(2, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // 3-cycle glitch on call[1] is rejected
    add(3, 4'h0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(6, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // bounce 1,0,1,1,1,... on call[1] gives a single pulse
    add(1, 4'h0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(5, 4'h0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'h0, 4'h2, 1, 4'h0, 4'h2, 4'h0, 4'h2, 8'h00);
    add(1, 4'h0, 4'h2, 1, 4'h0, 4'h2, 4'h0, 4'h0, 8'h00);
    add(5, 4'h0, 4'h0, 1, 4'h0, 4'h2, 4'h0, 4'h0, 8'h00);
    add(2, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    // all eight lines together
    add(5, 4'hF, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    add(1, 4'hF, 4'hF, 1, 4'hF, 4'hF, 4'hF, 4'hF, 8'h00);
    add(1, 4'hF, 4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 8'h00);
    add(5, 4'h0, 4'h0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 8'h00);
    add(2, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);

    foreach (vecs[i]) begin
      logic [23:0] want;
      drive(vecs[i].fb, vecs[i].call, vecs[i].en);
      sb_q.push_back(vecs[i].exp);
      tick();
      want = sb_q.pop_front();
      check($sformatf("row%0d", i), outs(), want);
    end

    // stuck on call[3]
    drive(4'h0, 4'h8, 1'b1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bus.call_level[3]) seen = 1;
    end
    check("stuck_rise_seen", 24'(seen), 24'h1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("stuck_hold_%0d", k), 24'(bus.stuck), (k >= 11) ? 24'h80 : 24'h0);
    end
    drive(4'h0, 4'h0, 1'b1);
    edges = 0;
    seen  = 0;
    while (edges < 20 && !seen) begin
      tick();
      edges++;
      if (!bus.call_level[3]) seen = 1;
      else check($sformatf("stuck_held_e%0d", edges), 24'(bus.stuck), 24'h80);
    end
    check("stuck_clear_with_level", 24'(bus.stuck), 24'h0);
    check("release_latency", 24'(edges), 24'(DB + 2));

    // async reset mid-operation with fb[1] held
    drive(4'h2, 4'h0, 1'b1);
    repeat (7) tick();
    check("pre_reset_level", 24'(bus.fb_level), 24'h2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outs", outs(), 24'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held_outs", outs(), 24'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rst_press_e%0d", k), 24'(bus.fb_press), (k == DB + 2) ? 24'h2 : 24'h0);
    end
    drive(4'h0, 4'h0, 1'b1);
    repeat (8) tick();
    check("final_idle", outs(), 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
